// File: rtl/freq_ctrl_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer.
// Holds the sequencer state enum, the BCD count width and the full-scale value.
package freq_ctrl_pkg;

   localparam int CNT_W = 24;
   localparam logic [CNT_W-1:0] BCD_MAX = 24'h999999;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      GATE,
      SETTLE,
      LATCH
   } state_t;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Sequencer <-> control/counter/readout signal bundle.
// master: START, ABORT, CNT_Q out; slave: CNT_ENA, CNT_CLR, BUSY, RESULT, DONE, OVF out.
interface freq_gate_ctrl_if;
   import freq_ctrl_pkg::*;

   logic             START;
   logic             ABORT;
   logic [CNT_W-1:0] CNT_Q;
   logic             CNT_ENA;
   logic             CNT_CLR;
   logic             BUSY;
   logic [CNT_W-1:0] RESULT;
   logic             DONE;
   logic             OVF;

   modport master (
      output START, ABORT, CNT_Q,
      input  CNT_ENA, CNT_CLR, BUSY, RESULT, DONE, OVF
   );

   modport slave (
      input  START, ABORT, CNT_Q,
      output CNT_ENA, CNT_CLR, BUSY, RESULT, DONE, OVF
   );

endinterface

// File: rtl/freq_gate_ctrl_timer.sv
// gate_timer: loadable down-counter with zero flag for the gate window.
// Ports: clk, clr (sync, active-high), load, dec, load_val in; zero out.
module gate_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Saturates at zero so the count can never wrap.
   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: gate/clear/latch sequencer for the 6-digit BCD event counter.
// Ports: F_IN clock, CLR sync active-high reset, bus (slave side of freq_gate_ctrl_if).
// Build option: CONT_MODE_EN makes measurements repeat back-to-back after one START.
module freq_gate_ctrl
   import freq_ctrl_pkg::*;
#(
   parameter int GATE_CYCLES = 1000
) (
   input  logic            F_IN,
   input  logic            CLR,
   freq_gate_ctrl_if.slave bus
);

   localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(GATE_CYCLES - 1);

   state_t           state;
   state_t           state_n;
   logic             t_load;
   logic             t_dec;
   logic             t_zero;
   logic [CNT_W-1:0] result;
   logic             done;
   logic             ovf;

   gate_timer #(.W(TW)) u_timer (
      .clk      (F_IN),
      .clr      (CLR),
      .load     (t_load),
      .dec      (t_dec),
      .load_val (LOAD_VAL),
      .zero     (t_zero)
   );

   always_ff @(posedge F_IN) begin
      if (CLR)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      t_load  = 1'b0;
      t_dec   = 1'b0;
      unique case (state)
         IDLE:
            if (bus.START)
               state_n = CLEAR;
         CLEAR: begin
            t_load  = 1'b1;
            state_n = GATE;
         end
         GATE: begin
            t_dec = 1'b1;
            if (t_zero)
               state_n = SETTLE;
         end
         SETTLE:
            state_n = LATCH;
         LATCH:
`ifdef CONT_MODE_EN
            state_n = CLEAR;
`else
            state_n = IDLE;
`endif
         default:
            state_n = IDLE;
      endcase
      // Abort only matters once a run is underway; START wins in IDLE.
      if (bus.ABORT && state != IDLE)
         state_n = IDLE;
   end

   // An aborted LATCH must leave RESULT/OVF untouched.
   always_ff @(posedge F_IN) begin
      if (CLR) begin
         result <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == LATCH && !bus.ABORT) begin
            result <= bus.CNT_Q;
            ovf    <= (bus.CNT_Q == BCD_MAX);
            done   <= 1'b1;
         end
      end
   end

   assign bus.CNT_CLR = (state == CLEAR);
   assign bus.CNT_ENA = (state == GATE);
   assign bus.BUSY    = (state != IDLE);
   assign bus.RESULT  = result;
   assign bus.DONE    = done;
   assign bus.OVF     = ovf;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: directed scenarios plus random traffic
// against a run-position reference model. Honors CONT_MODE_EN like the design.
module tb_freq_gate_ctrl;

   localparam int G = 10;
`ifdef CONT_MODE_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic F_IN = 1'b0;
   logic CLR  = 1'b1;

   freq_gate_ctrl_if bus ();

   freq_gate_ctrl #(.GATE_CYCLES(G)) dut (
      .F_IN (F_IN),
      .CLR  (CLR),
      .bus  (bus)
   );

   always #5 F_IN = ~F_IN;

   // Model: ph = position within a run (0 idle, 1 clear, 2..G+1 gate,
   // G+2 settle, G+3 latch).
   int          ph = 0;
   logic [23:0] m_res = '0;
   logic        m_ovf = 1'b0;
   logic        m_done = 1'b0;
   bit          valid = 1'b0;
   int          n_err = 0;
   int          n_chk = 0;
   int          cyc_n = 0;
   int          dones = 0;
   int          last_done = -1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, obs, exp, cyc_n);
      end
   endtask

   task automatic cyc(input bit clr, input bit st, input bit ab,
                      input logic [23:0] q);
      @(negedge F_IN);
      if (valid) begin
         chk("busy", 32'(bus.BUSY), 32'(ph != 0));
         chk("cnt_clr", 32'(bus.CNT_CLR), 32'(ph == 1));
         chk("cnt_ena", 32'(bus.CNT_ENA), 32'(ph >= 2 && ph <= G + 1));
         chk("done", 32'(bus.DONE), 32'(m_done));
         chk("result", 32'(bus.RESULT), 32'(m_res));
         chk("ovf", 32'(bus.OVF), 32'(m_ovf));
      end
      if (bus.DONE === 1'b1) begin
         dones++;
         last_done = cyc_n;
      end
      CLR       = clr;
      bus.START = st;
      bus.ABORT = ab;
      bus.CNT_Q = q;
      @(posedge F_IN);
      if (clr) begin
         ph = 0;
         m_res = '0;
         m_ovf = 1'b0;
         m_done = 1'b0;
         valid = 1'b1;
      end else begin
         m_done = (ph == G + 3) && !ab;
         if (m_done) begin
            m_res = q;
            m_ovf = (q == 24'h999999);
         end
         if (ph == 0)
            ph = st ? 1 : 0;
         else if (ab)
            ph = 0;
         else if (ph == G + 3)
            ph = CONT ? 1 : 0;
         else
            ph++;
      end
      cyc_n++;
   endtask

   task automatic run(input int upto, input int ab_at,
                      input int st_a, input int st_b,
                      input logic [23:0] q);
      cyc_n = 0;
      dones = 0;
      last_done = -1;
      cyc(0, 1, 0, q);
      while (cyc_n < upto)
         cyc(0, (cyc_n == st_a || cyc_n == st_b), (cyc_n == ab_at), q);
   endtask

   task automatic quiesce();
      cyc(0, 0, 1, 24'h0);
      cyc(0, 0, 0, 24'h0);
   endtask

   initial begin
      bus.START = 1'b1;
      bus.ABORT = 1'b0;
      bus.CNT_Q = '0;

      // Reset held with START high.
      cyc(1, 1, 0, 24'h0);
      cyc(1, 1, 0, 24'h0);
      cyc(0, 0, 0, 24'h0);

      // Plain run.
      run(16, -1, -1, -1, 24'h000123);
      chk("t2_dones", dones, 1);
      chk("t2_done_cyc", last_done, 14);
      chk("t2_result", 32'(bus.RESULT), 32'h000123);
      quiesce();

      // Abort mid-gate.
      run(20, 5, -1, -1, 24'h000456);
      chk("t3_dones", dones, 0);
      chk("t3_result", 32'(bus.RESULT), 32'h000123);
      quiesce();

      // START re-pulsed while busy.
      run(16, -1, 3, 8, 24'h000321);
      chk("t4_dones", dones, 1);
      chk("t4_done_cyc", last_done, 14);
      quiesce();

      // Overflow then clean run.
      run(16, -1, -1, -1, 24'h999999);
      chk("t5_ovf_hi", 32'(bus.OVF), 32'h1);
      quiesce();
      run(16, -1, -1, -1, 24'h000007);
      chk("t5_ovf_lo", 32'(bus.OVF), 32'h0);
      chk("t5_result", 32'(bus.RESULT), 32'h000007);
      quiesce();

      // Long run: repeats only in continuous mode.
      run(42, -1, -1, -1, 24'h000042);
      chk("t6_dones", dones, CONT ? 3 : 1);
      chk("t6_last", last_done, CONT ? 40 : 14);
      quiesce();
      dones = 0;
      repeat (30) cyc(0, 0, 0, 24'h0);
      chk("t6_stopped", dones, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [23:0] q;
         q = ($urandom % 4 == 0) ? 24'h999999 : 24'($urandom);
         cyc(($urandom % 200) == 0, ($urandom % 6) == 0,
             ($urandom % 50) == 0, q);
      end
      cyc(0, 0, 0, 24'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
